// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: status codes, grid bounds,
// colour-mux cell types and the apple generator state encoding.
package snake_pkg;

  localparam logic [1:0] GAME_PLAY = 2'b10;

  localparam logic [5:0] X_MIN = 6'd1;
  localparam logic [5:0] X_MAX = 6'd38;
  localparam logic [5:0] Y_MIN = 6'd1;
  localparam logic [5:0] Y_MAX = 6'd28;

  localparam logic [5:0] APPLE_RST_X = 6'd24;
  localparam logic [5:0] APPLE_RST_Y = 6'd10;

  typedef enum logic [2:0] {
    CellNone,
    CellHead,
    CellBody,
    CellWall,
    CellApple
  } cell_e;

  typedef enum logic [1:0] {
    StArmed,
    StEat,
    StSpawn
  } apple_state_e;

  function automatic logic cell_in_grid(input logic [5:0] x, input logic [5:0] y);
    return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/apple_gen.sv
// Apple generator: detects the head eating the apple, issues a held grow
// request, and respawns the apple at a random legal cell away from the head.
module apple_gen
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned ADD_HOLD = 4,
  parameter logic [31:0] TIMEOUT  = 32'd250000000,
  parameter int unsigned MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_status,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [6:0] cube_num,
  output logic       add_cube,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid
);

  localparam logic [3:0]  HoldLast = 4'(ADD_HOLD - 1);
  localparam logic [6:0]  MaxLen   = 7'(MAX_LEN);
  localparam logic [31:0] TmoLast  = TIMEOUT - 32'd1;

  apple_state_e state_q;
  logic [3:0]   hold_q;
  logic [31:0]  tmo_q;
  logic [15:0]  lfsr_q;

  logic [5:0] cand_x;
  logic [5:0] cand_y;
  logic       cand_ok;
  logic       play;
  logic       head_hit;
  logic       unused_lfsr;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  always_comb begin
    cand_x      = lfsr_q[5:0];
    cand_y      = {1'b0, lfsr_q[12:8]};
    cand_ok     = cell_in_grid(cand_x, cand_y) && !((cand_x == head_x) && (cand_y == head_y));
    play        = (game_status == GAME_PLAY);
    head_hit    = (head_x == apple_x) && (head_y == apple_y);
    unused_lfsr = ^{lfsr_q[15:13], lfsr_q[7:6]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StArmed;
      apple_x     <= APPLE_RST_X;
      apple_y     <= APPLE_RST_Y;
      apple_valid <= 1'b1;
      add_cube    <= 1'b0;
      hold_q      <= '0;
      tmo_q       <= '0;
    end else begin
      case (state_q)
        StArmed: begin
          // Eat takes priority over a timeout landing on the same cycle.
          if (play && head_hit) begin
            state_q     <= StEat;
            tmo_q       <= '0;
            apple_valid <= 1'b0;
            add_cube    <= (cube_num < MaxLen);
            hold_q      <= HoldLast;
          end else if (play && (TIMEOUT != 32'd0)) begin
            if (tmo_q == TmoLast) begin
              state_q     <= StSpawn;
              tmo_q       <= '0;
              apple_valid <= 1'b0;
            end else begin
              tmo_q <= tmo_q + 32'd1;
            end
          end
        end
        StEat: begin
          if (hold_q == 4'd0) begin
            state_q  <= StSpawn;
            add_cube <= 1'b0;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        StSpawn: begin
          // Rejection sampling: retry with the next LFSR value until legal.
          if (cand_ok) begin
            apple_x     <= cand_x;
            apple_y     <= cand_y;
            apple_valid <= 1'b1;
            tmo_q       <= '0;
            state_q     <= StArmed;
          end
        end
        default: state_q <= StArmed;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_gen.sv
// Randomized bench for apple_gen: behavioural model compared every cycle,
// plus literal checks for reset, eat, length cap, timeout and async reset.
module tb_apple_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int HOLD = 4;
  localparam int TMO  = 100;
  localparam int MAXL = 16;
  localparam logic [1:0] PLAY = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] game_status;
  logic [5:0] head_x, head_y;
  logic [6:0] cube_num;

  logic       add_cube, apple_valid;
  logic [5:0] apple_x, apple_y;
  logic       b_add, b_valid;
  logic [5:0] b_x, b_y;

  int checks = 0;
  int failures = 0;

  apple_gen #(.SEED(SEED), .ADD_HOLD(HOLD), .TIMEOUT(32'(TMO)), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .game_status(game_status), .head_x(head_x), .head_y(head_y),
    .cube_num(cube_num), .add_cube(add_cube), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid)
  );

  // Timeout disabled: used for the long hold-still check after reset.
  apple_gen #(.SEED(SEED), .ADD_HOLD(HOLD), .TIMEOUT(32'd0), .MAX_LEN(MAXL)) dut_big (
    .clk(clk), .reset(reset), .game_status(game_status), .head_x(head_x), .head_y(head_y),
    .cube_num(cube_num), .add_cube(b_add), .apple_x(b_x), .apple_y(b_y),
    .apple_valid(b_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] x, input logic [5:0] y);
    return (x >= 6'd1) && (x <= 6'd38) && (y >= 6'd1) && (y <= 6'd28);
  endfunction

  // Behavioural model: 0 = waiting for head, 1 = growing, 2 = placing apple.
  int         m_phase;
  int         m_left;
  int         m_tc;
  logic [5:0] m_ax, m_ay, m_cx, m_cy, m_acc_x, m_acc_y;
  logic       m_valid, m_add;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_tc = 0;
    m_ax = 6'd24; m_ay = 6'd10; m_valid = 1'b1; m_add = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic model_step();
    m_cx = m_lfsr[5:0];
    m_cy = {1'b0, m_lfsr[12:8]};
    if (m_phase == 0) begin
      if (game_status == PLAY && head_x == m_ax && head_y == m_ay) begin
        m_phase = 1; m_tc = 0; m_valid = 1'b0; m_left = HOLD;
        m_add = (int'(cube_num) < MAXL);
      end else if (game_status == PLAY) begin
        m_tc++;
        if (m_tc == TMO) begin
          m_phase = 2; m_tc = 0; m_valid = 1'b0;
        end
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 2; m_add = 1'b0;
      end
    end else begin
      if (legal(m_cx, m_cy) && !(m_cx == head_x && m_cy == head_y)) begin
        m_ax = m_cx; m_ay = m_cy; m_valid = 1'b1; m_phase = 0; m_tc = 0;
        m_acc_x = head_x; m_acc_y = head_y;
      end
    end
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, plus soak-time spawn checks.
  logic soak_en = 1'b0;
  logic prev_valid = 1'b1;
  int   low_run = 0;
  int   n_spawn = 0;

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({add_cube, apple_valid, apple_x, apple_y} !== {m_add, m_valid, m_ax, m_ay}) begin
        failures++;
        $display("FAIL model_cmp actual add=%b valid=%b apple=(%0d,%0d) required add=%b valid=%b apple=(%0d,%0d)",
                 add_cube, apple_valid, apple_x, apple_y, m_add, m_valid, m_ax, m_ay);
      end
      if (soak_en && apple_valid && !prev_valid) begin
        n_spawn++;
        chk("soak_bounds", 32'(legal(apple_x, apple_y)), 32'd1);
        chk("soak_not_head", 32'({apple_x, apple_y} != {m_acc_x, m_acc_y}), 32'd1);
        chk("soak_residency", 32'(low_run <= 65536 + HOLD), 32'd1);
      end
      low_run    = apple_valid ? 0 : low_run + 1;
      prev_valid = apple_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!apple_valid && k < 70000) begin
      tick(); #1; k++;
    end
    chk(name, 32'(apple_valid), 32'd1);
  endtask

  task automatic restart(input logic [5:0] hx, input logic [5:0] hy, input logic [6:0] cn);
    tick();
    reset = 1'b0;
    game_status = PLAY; head_x = hx; head_y = hy; cube_num = cn;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [9:0] hist;
    int n;
    game_status = PLAY; head_x = 6'd10; head_y = 6'd5; cube_num = 7'd3;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_apple", 32'({apple_valid, add_cube, apple_x, apple_y}), 32'({1'b1, 1'b0, 6'd24, 6'd10}));
    chk("model_seed", 32'(m_lfsr), 32'hACE1);
    reset = 1'b1;
    tick();
    chk("model_lfsr_step", 32'(m_lfsr), 32'h59C3);

    // Hold still for 1000 cycles with the timeout disabled.
    for (int i = 0; i < 1000; i++) begin
      tick(); #1;
      chk("rst_hold", 32'({b_add, b_valid, b_x, b_y}), 32'({1'b0, 1'b1, 6'd24, 6'd10}));
    end

    // Single eat at the reset apple position.
    restart(6'd24, 6'd10, 7'd3);
    hist = '0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      hist[i] = add_cube;
      if (i == 0) chk("eat_valid_low", 32'(apple_valid), 32'd0);
    end
    chk("eat_add_pulse", 32'(hist), 32'b0000001111);
    wait_valid("eat_respawn");
    chk("eat_new_bounds", 32'(legal(apple_x, apple_y)), 32'd1);
    chk("eat_new_not_head", 32'({apple_x, apple_y} != {6'd24, 6'd10}), 32'd1);

    // Length cap: no grow request, apple still moves.
    restart(6'd24, 6'd10, 7'd16);
    hist = '0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      hist[i] = add_cube;
    end
    chk("cap_no_add", 32'(hist), 32'd0);
    wait_valid("cap_respawn");
    chk("cap_moved", 32'({apple_x, apple_y} != {6'd24, 6'd10}), 32'd1);

    // Timeout relocation, uninterrupted.
    restart(6'd10, 6'd5, 7'd3);
    n = 0;
    while (apple_valid && n < 5000) begin
      tick(); n++; #1;
    end
    chk("tmo_cycles", 32'(n), 32'd100);
    chk("tmo_no_add", 32'(add_cube), 32'd0);

    // Timeout with 50 paused cycles in the middle.
    restart(6'd10, 6'd5, 7'd3);
    n = 0;
    while (apple_valid && n < 5000) begin
      tick(); n++;
      game_status = (n >= 20 && n < 70) ? 2'b01 : PLAY;
      #1;
    end
    game_status = PLAY;
    chk("tmo_pause_cycles", 32'(n), 32'd150);

    // Asynchronous reset during the second grow cycle.
    restart(6'd24, 6'd10, 7'd3);
    tick(); tick(); #1;
    chk("areset_pre_add", 32'(add_cube), 32'd1);
    reset = 1'b0;
    #1;
    chk("areset_add_drop", 32'(add_cube), 32'd0);
    tick();
    reset = 1'b1;
    head_x = 6'd10; head_y = 6'd5;
    #1;
    chk("areset_apple", 32'({apple_valid, apple_x, apple_y}), 32'({1'b1, 6'd24, 6'd10}));

    // Soak: eat repeatedly, steer the head onto spawn candidates.
    soak_en = 1'b1;
    n = 0;
    while (n_spawn < 2000 && n < 60000) begin
      tick(); n++;
      game_status = ($urandom_range(0, 9) == 0) ? 2'b01 : PLAY;
      cube_num = 7'($urandom_range(0, 20));
      if (m_phase == 0) begin
        head_x = m_ax; head_y = m_ay;
      end else if (m_phase == 2 && $urandom_range(0, 1) == 1 &&
                   legal(m_lfsr[5:0], {1'b0, m_lfsr[12:8]})) begin
        head_x = m_lfsr[5:0]; head_y = {1'b0, m_lfsr[12:8]};
      end else begin
        head_x = 6'($urandom_range(1, 38)); head_y = 6'($urandom_range(1, 28));
      end
    end
    chk("soak_spawn_count", 32'(n_spawn >= 2000), 32'd1);
    soak_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
